// File: rtl/gg_fpga.sv
// Shared FPGA type definitions: trigger/hitting mode selectors and the
// state encoding of the hit pulse generator.
package gg_fpga;

  typedef enum logic {
    STATIC      = 1'b0,
    BOUNCE_BACK = 1'b1
  } trigger_mode_t;

  typedef enum logic {
    MANUAL         = 1'b0,
    AUTO_HIT_WIDTH = 1'b1
  } hitting_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIT    = 2'd1,
    GAP    = 2'd2,
    RETURN = 2'd3
  } hit_state_t;

  localparam logic [15:0] HIT_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hit_pulse_gen.sv
// Hit pulse generator: rising edge on trig_in launches a hit, optionally
// followed by a gap and a return hit. Define HIT_PULSE_GEN_COUNTER_EN for hit_count.
module hit_pulse_gen
  import gg_fpga::*;
#(
  parameter int WIDTH_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  trigger_mode_t      trigger_mode,
  input  hitting_mode_t      hitting_mode,
  input  logic [WIDTH_W-1:0] hit_width,
  input  logic               trig_in,
  output logic               hit_out,
  output logic               bounce_out,
  output logic               busy,
  output logic               dropped
`ifdef HIT_PULSE_GEN_COUNTER_EN
  ,
  output logic [15:0]        hit_count
`endif
);

  hit_state_t         state_q;
  trigger_mode_t      trig_mode_q;
  hitting_mode_t      hit_mode_q;
  logic [WIDTH_W-1:0] width_q;
  logic [WIDTH_W-1:0] cnt_q;
  logic               trig_q;
  logic               hit_out_q;
  logic               bounce_out_q;
  logic               busy_q;
  logic               dropped_q;

  logic               rise;
  logic [WIDTH_W-1:0] width_eff;
  logic               cnt_last;
  logic               hit_done;

  assign rise      = trig_in & ~trig_q;
  // A zero width would never terminate the down-counter, so it is promoted to 1.
  assign width_eff = (hit_width == '0) ? WIDTH_W'(1) : hit_width;
  assign cnt_last  = (cnt_q == WIDTH_W'(1));
  assign hit_done  = (hit_mode_q == MANUAL) ? ~trig_in : cnt_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      trig_mode_q  <= STATIC;
      hit_mode_q   <= MANUAL;
      width_q      <= '0;
      cnt_q        <= '0;
      trig_q       <= 1'b1;
      hit_out_q    <= 1'b0;
      bounce_out_q <= 1'b0;
      busy_q       <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      trig_q    <= trig_in;
      dropped_q <= rise && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (rise) begin
            trig_mode_q <= trigger_mode;
            hit_mode_q  <= hitting_mode;
            width_q     <= width_eff;
            cnt_q       <= width_eff;
            state_q     <= HIT;
            hit_out_q   <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        HIT: begin
          if (hit_done) begin
            hit_out_q <= 1'b0;
            if (trig_mode_q == STATIC) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= GAP;
              cnt_q   <= width_q;
            end
          end else if (hit_mode_q == AUTO_HIT_WIDTH) begin
            cnt_q <= cnt_q - WIDTH_W'(1);
          end
        end
        GAP: begin
          if (cnt_last) begin
            state_q      <= RETURN;
            cnt_q        <= width_q;
            hit_out_q    <= 1'b1;
            bounce_out_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - WIDTH_W'(1);
          end
        end
        RETURN: begin
          if (cnt_last) begin
            state_q      <= IDLE;
            hit_out_q    <= 1'b0;
            bounce_out_q <= 1'b0;
            busy_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - WIDTH_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hit_out    = hit_out_q;
  assign bounce_out = bounce_out_q;
  assign busy       = busy_q;
  assign dropped    = dropped_q;

`ifdef HIT_PULSE_GEN_COUNTER_EN
  logic [15:0] hit_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q <= '0;
    end else if ((state_q == IDLE) && rise && (hit_count_q != HIT_COUNT_MAX)) begin
      hit_count_q <= hit_count_q + 16'd1;
    end
  end

  assign hit_count = hit_count_q;
`endif

endmodule
